// File: rtl/dp_bram_pkg.sv
// Shared constants and write-mode decoding for the 16Kx1 dual-port block RAM.
package dp_bram_pkg;

   localparam int unsigned ADDR_W   = 14;
   localparam int unsigned DATA_W   = 1;
   localparam int unsigned DEPTH    = 16384;
   localparam int unsigned WM_STR_W = 88;

   typedef enum logic [1:0] {
      WM_WRITE_FIRST,
      WM_READ_FIRST,
      WM_NO_CHANGE
   } write_mode_e;

   // Unrecognised strings fall back to WRITE_FIRST, the primitive's default.
   function automatic write_mode_e wm_from_string(input logic [WM_STR_W-1:0] s);
      if (s == WM_STR_W'("READ_FIRST"))
         return WM_READ_FIRST;
      else if (s == WM_STR_W'("NO_CHANGE"))
         return WM_NO_CHANGE;
      else
         return WM_WRITE_FIRST;
   endfunction

endpackage

// File: rtl/dp_bram_port_out.sv
// One port's registered read output: reset value, enable hold and write-mode mux.
module dp_bram_port_out
   import dp_bram_pkg::*;
#(
   parameter write_mode_e       WMODE = WM_WRITE_FIRST,
   parameter logic [DATA_W-1:0] INIT  = '0,
   parameter logic [DATA_W-1:0] SRVAL = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en,
   input  logic              we,
   input  logic [DATA_W-1:0] di,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] q = INIT;
   logic [DATA_W-1:0] q_next;

   always_comb begin
      q_next = q;
      if (en) begin
         if (!we) begin
            q_next = rd_data;
         end else begin
            unique case (WMODE)
               WM_WRITE_FIRST: q_next = di;
               WM_READ_FIRST:  q_next = rd_data;
               WM_NO_CHANGE:   q_next = q;
               default:        q_next = di;
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         q <= SRVAL;
      else
         q <= q_next;
   end

   assign dout = q;

endmodule

// File: rtl/dp_bram_16kx1.sv
// Behavioural 16384x1 true dual-port block RAM with per-port write modes.
module dp_bram_16kx1
  import dp_bram_pkg::*;
#(
  parameter                    WRITE_MODE_A = "WRITE_FIRST",
  parameter                    WRITE_MODE_B = "WRITE_FIRST",
  parameter logic [DATA_W-1:0] INIT_A       = '0,
  parameter logic [DATA_W-1:0] INIT_B       = '0,
  parameter logic [DATA_W-1:0] SRVAL_A      = '0,
  parameter logic [DATA_W-1:0] SRVAL_B      = '0,
  parameter                    INIT_FILE    = ""
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dia,
  output logic [DATA_W-1:0] doa,
  input  logic              enb,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dib,
  output logic [DATA_W-1:0] dob
);

  localparam write_mode_e WM_A = wm_from_string(WM_STR_W'(WRITE_MODE_A));
  localparam write_mode_e WM_B = wm_from_string(WM_STR_W'(WRITE_MODE_B));

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // Reads see pre-edge contents, so a port reading a word the other port writes gets old data.
  assign rd_a = mem[addra];
  assign rd_b = mem[addrb];

  // Port A is written last so it wins a same-address double write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (enb && web)
        mem[addrb] <= dib;
      if (ena && wea)
        mem[addra] <= dia;
    end
  end

  dp_bram_port_out #(
    .WMODE (WM_A),
    .INIT  (INIT_A),
    .SRVAL (SRVAL_A)
  ) u_out_a (
    .clock   (clock),
    .reset   (reset),
    .en      (ena),
    .we      (wea),
    .di      (dia),
    .rd_data (rd_a),
    .dout    (doa)
  );

  dp_bram_port_out #(
    .WMODE (WM_B),
    .INIT  (INIT_B),
    .SRVAL (SRVAL_B)
  ) u_out_b (
    .clock   (clock),
    .reset   (reset),
    .en      (enb),
    .we      (web),
    .di      (dib),
    .rd_data (rd_b),
    .dout    (dob)
  );

endmodule

// File: tb/tb_dp_bram_16kx1.sv
// Self-checking bench: three write-mode variants driven in lockstep against a reference model.
module tb_dp_bram_16kx1;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
   logic [13:0] addra = '0, addrb = '0;
   logic        dia = 1'b0, dib = 1'b0;
   logic        doa_wf, doa_rf, doa_nc;
   logic        dob_wf, dob_rf, dob_nc;

   int unsigned checks = 0;
   int unsigned failures = 0;

   // Reference model: plain storage array plus expected outputs per port-A mode (0=WF, 1=RF, 2=NC).
   bit   ref_mem [16384];
   logic exp_a [3];
   logic exp_b;

   always #5 clock = ~clock;

   dp_bram_16kx1 #(.WRITE_MODE_A("WRITE_FIRST")) u_wf (
      .clock(clock), .reset(reset),
      .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa_wf),
      .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob_wf));

   dp_bram_16kx1 #(.WRITE_MODE_A("READ_FIRST")) u_rf (
      .clock(clock), .reset(reset),
      .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa_rf),
      .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob_rf));

   dp_bram_16kx1 #(.WRITE_MODE_A("NO_CHANGE")) u_nc (
      .clock(clock), .reset(reset),
      .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa_nc),
      .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob_nc));

   // Apply one clock edge to the model using the currently driven inputs, then wait for the DUT.
   task automatic cycle();
      bit old_a, old_b;
      old_a = ref_mem[addra];
      old_b = ref_mem[addrb];
      if (reset) begin
         exp_a[0] = 1'b0; exp_a[1] = 1'b0; exp_a[2] = 1'b0;
         exp_b    = 1'b0;
      end else begin
         if (ena) begin
            if (!wea) begin
               exp_a[0] = old_a; exp_a[1] = old_a; exp_a[2] = old_a;
            end else begin
               exp_a[0] = dia;
               exp_a[1] = old_a;
            end
         end
         if (enb)
            exp_b = web ? dib : old_b;
         if (enb && web) ref_mem[addrb] = dib;
         if (ena && wea) ref_mem[addra] = dia;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic check_all(input string tag);
      checks++;
      assert (doa_wf === exp_a[0]) else begin
         failures++;
         $error("FAIL %s doa_wf observed=%b expected=%b", tag, doa_wf, exp_a[0]);
      end
      checks++;
      assert (doa_rf === exp_a[1]) else begin
         failures++;
         $error("FAIL %s doa_rf observed=%b expected=%b", tag, doa_rf, exp_a[1]);
      end
      checks++;
      assert (doa_nc === exp_a[2]) else begin
         failures++;
         $error("FAIL %s doa_nc observed=%b expected=%b", tag, doa_nc, exp_a[2]);
      end
      checks++;
      assert (dob_wf === exp_b && dob_rf === exp_b && dob_nc === exp_b) else begin
         failures++;
         $error("FAIL %s dob observed=%b/%b/%b expected=%b", tag, dob_wf, dob_rf, dob_nc, exp_b);
      end
   endtask

   task automatic drive(input logic a_en, input logic a_we, input int unsigned a_addr, input logic a_d,
                        input logic b_en, input logic b_we, input int unsigned b_addr, input logic b_d);
      ena = a_en; wea = a_we; addra = 14'(a_addr); dia = a_d;
      enb = b_en; web = b_we; addrb = 14'(b_addr); dib = b_d;
   endtask

   initial begin
      exp_a[0] = 1'b0; exp_a[1] = 1'b0; exp_a[2] = 1'b0;
      exp_b    = 1'b0;

      // Time-zero values come from INIT_A/INIT_B.
      #1;
      check_all("time_zero");

      // Reset with both ports enabled and writing; memory must stay untouched.
      reset = 1'b1;
      drive(1, 1, 'h0040, 1, 1, 1, 'h0041, 1);
      for (int i = 0; i < 2; i++) begin
         cycle();
         check_all("reset_hold");
      end
      reset = 1'b0;
      drive(1, 0, 'h0041, 0, 1, 0, 'h0040, 0);
      cycle();
      check_all("reset_no_write");

      // Basic write via A then read via B; A reads an untouched neighbour.
      drive(1, 1, 'h0005, 1, 0, 0, 'h0000, 0);
      cycle();
      check_all("basic_write");
      drive(1, 0, 'h0006, 0, 1, 0, 'h0005, 0);
      cycle();
      check_all("basic_read");
      checks++;
      assert (dob_wf === 1'b1) else begin
         failures++;
         $error("FAIL basic_dob_const observed=%b expected=1", dob_wf);
      end

      // Write modes at the top address: load doa with 1 so NO_CHANGE is distinguishable.
      drive(1, 0, 'h0005, 0, 0, 0, 'h0000, 0);
      cycle();
      check_all("wm_preload");
      drive(1, 1, 'h3FFF, 1, 0, 0, 'h0000, 0);
      cycle();
      check_all("wm_write_top");
      checks++;
      assert (doa_wf === 1'b1 && doa_rf === 1'b0 && doa_nc === 1'b1) else begin
         failures++;
         $error("FAIL wm_const observed=%b%b%b expected=101", doa_wf, doa_rf, doa_nc);
      end

      // Disabled port A: no write, output holds.
      drive(0, 1, 'h0010, 1, 0, 0, 'h0000, 0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_all("en_hold");
      end
      drive(1, 0, 'h0010, 0, 1, 0, 'h0010, 0);
      cycle();
      check_all("en_no_write");

      // Collisions.
      drive(1, 1, 'h0020, 1, 1, 0, 'h0020, 0);
      cycle();
      check_all("coll_a_wr_b_rd");
      drive(0, 0, 'h0000, 0, 1, 0, 'h0020, 0);
      cycle();
      check_all("coll_after");
      drive(1, 1, 'h0021, 0, 1, 1, 'h0021, 1);
      cycle();
      check_all("coll_both_wr");
      drive(0, 0, 'h0000, 0, 1, 0, 'h0021, 0);
      cycle();
      check_all("coll_both_rd");
      checks++;
      assert (dob_wf === 1'b0) else begin
         failures++;
         $error("FAIL coll_a_wins observed=%b expected=0", dob_wf);
      end

      // Random traffic over a small window to provoke collisions, with occasional resets.
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 19) == 0);
         drive(1'($urandom), 1'($urandom), 'h0100 + $urandom_range(0, 3), 1'($urandom),
               1'($urandom), 1'($urandom), 'h0100 + $urandom_range(0, 3), 1'($urandom));
         cycle();
         check_all("random");
      end
      reset = 1'b0;

      // Full sweep: pattern addr[0]^addr[13] written via A, read back via B.
      for (int unsigned a = 0; a < 16384; a++) begin
         drive(1, 1, a, 1'(a ^ (a >> 13)), 0, 0, 0, 0);
         cycle();
      end
      for (int unsigned a = 0; a < 16384; a++) begin
         drive(0, 0, 0, 0, 1, 0, a, 0);
         cycle();
         checks++;
         assert (dob_wf === 1'(a ^ (a >> 13)) && dob_wf === exp_b) else begin
            failures++;
            $error("FAIL sweep addr=%0d observed=%b expected=%b", a, dob_wf, 1'(a ^ (a >> 13)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
